// File: rtl/pipe_stage_pkg.sv
// Shared constants and types for the elastic pipeline-stage buffer.
// No logic; consumed by pipe_stage_buf and pipe_stage_perf.
// Pointer width helper keeps DEPTH=1 from producing a zero-width pointer.
package pipe_stage_pkg;

    localparam int PIPE_STAGE_MAX_DEPTH = 4;

    typedef logic [31:0] perf_cnt_t;

    // Pointer width for a queue of 'depth' entries, never below one bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage : pipe_stage_pkg

// File: rtl/pipe_stage_perf.sv
// Saturating performance counters for pipe_stage_buf (built only with PIPE_STAGE_BUF_PERF_EN).
// Latency: each event is reflected in its counter one edge after it occurs.
// Backpressure: none; purely observes, counters stick at all-ones and clear on RST.
`ifdef PIPE_STAGE_BUF_PERF_EN
module pipe_stage_perf
    import pipe_stage_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall_evt_i,
    input  logic        full_evt_i,
    input  logic        flush_evt_i,
    output perf_cnt_t   stall_cycles_o,
    output perf_cnt_t   full_cycles_o,
    output logic [15:0] flush_events_o
);

    perf_cnt_t   stall_q, stall_d;
    perf_cnt_t   full_q,  full_d;
    logic [15:0] flush_q, flush_d;

    // Increment on each event unless the counter has already saturated.
    always_comb begin
        stall_d = stall_q;
        full_d  = full_q;
        flush_d = flush_q;
        if (stall_evt_i && (stall_q != '1)) stall_d = stall_q + 32'd1;
        if (full_evt_i  && (full_q  != '1)) full_d  = full_q  + 32'd1;
        if (flush_evt_i && (flush_q != '1)) flush_d = flush_q + 16'd1;
    end

    // Counter registers; reset wins over any event in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            full_q  <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            full_q  <= full_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles_o = stall_q;
    assign full_cycles_o  = full_q;
    assign flush_events_o = flush_q;

endmodule : pipe_stage_perf
`endif

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: DEPTH-entry circular queue with flush (optional PIPE_STAGE_BUF_PERF_EN counters).
// Latency: an entry pushed on edge t is at out_data/out_valid after that edge; no bypass.
// Backpressure: in_ready drops when full (READY_REG=0 also accepts when full and out_ready) and during flush.
module pipe_stage_buf
    import pipe_stage_pkg::*;
#(
    parameter int W         = 32,   // 1..512
    parameter int DEPTH     = 2,    // 1..PIPE_STAGE_MAX_DEPTH
    parameter int READY_REG = 0     // 1: in_ready independent of out_ready
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    output perf_cnt_t                    stall_cycles,
    output perf_cnt_t                    full_cycles,
    output logic [15:0]                  flush_events
`endif
);

    localparam int            PW      = ptr_w(DEPTH);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          not_full;
    logic          push;
    logic          pop;

    // Explicit wrap so DEPTH=3 cycles 0,1,2,0 instead of running into index 3.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    assign not_full = (count_q < DEPTH_C);

    generate
        if (READY_REG != 0) begin : g_ready_reg
            assign in_ready = !flush && not_full;
        end else begin : g_ready_comb
            // Full but draining this cycle still frees a slot for a simultaneous push.
            assign in_ready = !flush && (not_full || out_ready);
        end
    endgenerate

    assign out_valid = (count_q != '0) && !flush;
    assign out_data  = mem_q[rd_ptr_q];
    assign occupancy = count_q;

    assign push = in_valid  && in_ready  && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Next pointers and count; flush squashes everything and rewinds both pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State and storage; reset clears the payload too so out_data is defined.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_BUF_PERF_EN
    pipe_stage_perf u_perf (
        .CLK            (CLK),
        .RST            (RST),
        .stall_evt_i    (out_valid && !out_ready),
        .full_evt_i     (count_q == DEPTH_C),
        .flush_evt_i    (flush),
        .stall_cycles_o (stall_cycles),
        .full_cycles_o  (full_cycles),
        .flush_events_o (flush_events)
    );
`endif

endmodule : pipe_stage_buf

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: three instances (D2/RR1, D1/RR0, D3/RR0) sharing clock and reset.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// Perf counter scenario is compiled only when PIPE_STAGE_BUF_PERF_EN is defined.
module tb_pipe_stage_buf;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // DEPTH=2, READY_REG=1
    logic        d2_flush, d2_iv, d2_ir, d2_ov, d2_or;
    logic [31:0] d2_id, d2_od;
    logic [1:0]  d2_occ;
    // DEPTH=1, READY_REG=0
    logic        d1_flush, d1_iv, d1_ir, d1_ov, d1_or;
    logic [31:0] d1_id, d1_od;
    logic [0:0]  d1_occ;
    // DEPTH=3, READY_REG=0
    logic        d3_flush, d3_iv, d3_ir, d3_ov, d3_or;
    logic [31:0] d3_id, d3_od;
    logic [1:0]  d3_occ;
`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [31:0] d2_sc, d2_fc, d1_sc, d1_fc, d3_sc, d3_fc;
    logic [15:0] d2_fe, d1_fe, d3_fe;
`endif

    pipe_stage_buf #(.W(32), .DEPTH(2), .READY_REG(1)) u_d2 (
        .CLK(CLK), .RST(RST), .flush(d2_flush),
        .in_valid(d2_iv), .in_ready(d2_ir), .in_data(d2_id),
        .out_valid(d2_ov), .out_ready(d2_or), .out_data(d2_od),
        .occupancy(d2_occ)
`ifdef PIPE_STAGE_BUF_PERF_EN
        , .stall_cycles(d2_sc), .full_cycles(d2_fc), .flush_events(d2_fe)
`endif
    );

    pipe_stage_buf #(.W(32), .DEPTH(1), .READY_REG(0)) u_d1 (
        .CLK(CLK), .RST(RST), .flush(d1_flush),
        .in_valid(d1_iv), .in_ready(d1_ir), .in_data(d1_id),
        .out_valid(d1_ov), .out_ready(d1_or), .out_data(d1_od),
        .occupancy(d1_occ)
`ifdef PIPE_STAGE_BUF_PERF_EN
        , .stall_cycles(d1_sc), .full_cycles(d1_fc), .flush_events(d1_fe)
`endif
    );

    pipe_stage_buf #(.W(32), .DEPTH(3), .READY_REG(0)) u_d3 (
        .CLK(CLK), .RST(RST), .flush(d3_flush),
        .in_valid(d3_iv), .in_ready(d3_ir), .in_data(d3_id),
        .out_valid(d3_ov), .out_ready(d3_or), .out_data(d3_od),
        .occupancy(d3_occ)
`ifdef PIPE_STAGE_BUF_PERF_EN
        , .stall_cycles(d3_sc), .full_cycles(d3_fc), .flush_events(d3_fe)
`endif
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        d2_iv = 1'b1; d2_id = 32'hDEADBEEF;
        step();
        @(negedge CLK);
        n_cmp++; if (d2_ir !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", d2_ir); end
        n_cmp++; if (d2_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_during: got %b, expected 0", d2_ov); end
        step();
        RST = 1'b0;
        d2_iv = 1'b0;
        @(negedge CLK);
        n_cmp++; if (d2_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", d2_ov); end
        n_cmp++; if (d2_od !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h, expected 0", d2_od); end
        n_cmp++; if (d2_occ !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d, expected 0", d2_occ); end
        n_cmp++; if (d1_od !== 32'h0 || d1_ov !== 1'b0) begin n_fail++; $display("FAIL reset_d1: got v=%b d=%h, expected v=0 d=0", d1_ov, d1_od); end
        n_cmp++; if (d3_od !== 32'h0 || d3_occ !== 2'd0) begin n_fail++; $display("FAIL reset_d3: got occ=%0d d=%h, expected 0/0", d3_occ, d3_od); end
        step();
        @(negedge CLK);
        n_cmp++; if (d2_ov !== 1'b0 || d2_occ !== 2'd0) begin n_fail++; $display("FAIL reset_no_entry: got v=%b occ=%0d, expected 0/0", d2_ov, d2_occ); end
    endtask

    task automatic test_fill_drain();
        step();
        d2_iv = 1'b1; d2_id = 32'h11; d2_or = 1'b0;
        step();
        d2_id = 32'h22;
        @(negedge CLK);
        n_cmp++; if (d2_ov !== 1'b1 || d2_od !== 32'h11) begin n_fail++; $display("FAIL fill_first_latency: got v=%b d=%h, expected 1/11", d2_ov, d2_od); end
        n_cmp++; if (d2_occ !== 2'd1) begin n_fail++; $display("FAIL fill_occ1: got %0d, expected 1", d2_occ); end
        step();
        d2_iv = 1'b0;
        @(negedge CLK);
        n_cmp++; if (d2_occ !== 2'd2) begin n_fail++; $display("FAIL fill_occ2: got %0d, expected 2", d2_occ); end
        n_cmp++; if (d2_ir !== 1'b0) begin n_fail++; $display("FAIL fill_full_in_ready: got %b, expected 0", d2_ir); end
        step();
        d2_or = 1'b1;
        @(negedge CLK);
        n_cmp++; if (d2_ov !== 1'b1 || d2_od !== 32'h11) begin n_fail++; $display("FAIL drain_first: got v=%b d=%h, expected 1/11", d2_ov, d2_od); end
        n_cmp++; if (d2_ir !== 1'b0) begin n_fail++; $display("FAIL drain_rr1_in_ready: got %b, expected 0", d2_ir); end
        step();
        @(negedge CLK);
        n_cmp++; if (d2_ov !== 1'b1 || d2_od !== 32'h22) begin n_fail++; $display("FAIL drain_second: got v=%b d=%h, expected 1/22", d2_ov, d2_od); end
        step();
        d2_or = 1'b0;
        @(negedge CLK);
        n_cmp++; if (d2_ov !== 1'b0 || d2_occ !== 2'd0) begin n_fail++; $display("FAIL drain_empty: got v=%b occ=%0d, expected 0/0", d2_ov, d2_occ); end
    endtask

    task automatic test_stream();
        step();
        d1_iv = 1'b1; d1_or = 1'b1; d1_id = 32'd1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i < 10) d1_id = 32'(i + 1);
            else        d1_iv = 1'b0;
            @(negedge CLK);
            n_cmp++; if (d1_ov !== 1'b1 || d1_od !== 32'(i)) begin n_fail++; $display("FAIL stream_out[%0d]: got v=%b d=%0d, expected 1/%0d", i, d1_ov, d1_od, i); end
            if (i < 10) begin
                n_cmp++; if (d1_ir !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b, expected 1", i, d1_ir); end
            end
        end
        step();
        d1_or = 1'b0;
        @(negedge CLK);
        n_cmp++; if (d1_ov !== 1'b0 || d1_occ !== 1'b0) begin n_fail++; $display("FAIL stream_end: got v=%b occ=%0d, expected 0/0", d1_ov, d1_occ); end
    endtask

    task automatic test_flush();
        step();
        d3_or = 1'b0; d3_iv = 1'b1; d3_id = 32'hA;
        step(); d3_id = 32'hB;
        step(); d3_id = 32'hC;
        step(); d3_iv = 1'b0;
        @(negedge CLK);
        n_cmp++; if (d3_occ !== 2'd3 || d3_od !== 32'hA) begin n_fail++; $display("FAIL flush_prefill: got occ=%0d d=%h, expected 3/a", d3_occ, d3_od); end
        n_cmp++; if (d3_ir !== 1'b0) begin n_fail++; $display("FAIL flush_full_in_ready: got %b, expected 0", d3_ir); end
        step();
        d3_flush = 1'b1; d3_iv = 1'b1; d3_id = 32'hD; d3_or = 1'b1;
        @(negedge CLK);
        n_cmp++; if (d3_ir !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b, expected 0", d3_ir); end
        n_cmp++; if (d3_ov !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b, expected 0", d3_ov); end
        step();
        d3_flush = 1'b0; d3_iv = 1'b0;
        @(negedge CLK);
        n_cmp++; if (d3_occ !== 2'd0 || d3_ov !== 1'b0) begin n_fail++; $display("FAIL flush_after: got occ=%0d v=%b, expected 0/0", d3_occ, d3_ov); end
        n_cmp++; if (d3_od !== 32'hA) begin n_fail++; $display("FAIL flush_mem_kept: got %h, expected a", d3_od); end
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge CLK);
            n_cmp++; if (d3_ov !== 1'b0) begin n_fail++; $display("FAIL flush_no_d[%0d]: got v=%b d=%h, expected v=0", i, d3_ov, d3_od); end
        end
        step();
        d3_iv = 1'b1; d3_id = 32'hE;
        step();
        d3_iv = 1'b0;
        @(negedge CLK);
        n_cmp++; if (d3_ov !== 1'b1 || d3_od !== 32'hE) begin n_fail++; $display("FAIL flush_restart: got v=%b d=%h, expected 1/e", d3_ov, d3_od); end
        step();
        d3_or = 1'b0;
        @(negedge CLK);
        n_cmp++; if (d3_occ !== 2'd0) begin n_fail++; $display("FAIL flush_restart_drain: got %0d, expected 0", d3_occ); end
    endtask

    task automatic test_wrap();
        logic [15:0] pat;
        logic [31:0] expq [$];
        logic        exp_rdy;
        int          sent;
        int          got;
        pat  = 16'b1111_0011_1011_0000;
        sent = 0;
        got  = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            d3_or = pat[c % 16];
            d3_iv = (sent < 7);
            d3_id = 32'h50 + 32'(sent) + 32'd1;
            @(negedge CLK);
            exp_rdy = (expq.size() < 3) || d3_or;
            n_cmp++; if (d3_ir !== exp_rdy) begin n_fail++; $display("FAIL wrap_in_ready[c%0d]: got %b, expected %b", c, d3_ir, exp_rdy); end
            n_cmp++; if (d3_occ !== 2'(expq.size()) || d3_occ > 2'd3) begin n_fail++; $display("FAIL wrap_occ[c%0d]: got %0d, expected %0d", c, d3_occ, expq.size()); end
            n_cmp++; if (d3_ov !== (expq.size() != 0)) begin n_fail++; $display("FAIL wrap_out_valid[c%0d]: got %b, expected %b", c, d3_ov, expq.size() != 0); end
            if (expq.size() != 0 && d3_or) begin
                n_cmp++; if (d3_od !== expq[0]) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h, expected %h", got, d3_od, expq[0]); end
                void'(expq.pop_front());
                got++;
            end
            if (d3_iv && exp_rdy) begin
                expq.push_back(d3_id);
                sent++;
            end
            if (sent == 7 && expq.size() == 0) break;
        end
        step();
        d3_iv = 1'b0; d3_or = 1'b0;
        n_cmp++; if (got != 7) begin n_fail++; $display("FAIL wrap_count: got %0d outputs, expected 7", got); end
    endtask

`ifdef PIPE_STAGE_BUF_PERF_EN
    task automatic test_perf();
        RST = 1'b1;
        step(); step();
        RST = 1'b0;
        d2_or = 1'b0; d2_iv = 1'b1; d2_id = 32'h77;
        step();
        d2_iv = 1'b0;
        for (int i = 0; i < 5; i++) step();
        d2_flush = 1'b1;
        step();
        d2_flush = 1'b0;
        @(negedge CLK);
        n_cmp++; if (d2_sc !== 32'd5) begin n_fail++; $display("FAIL perf_stall: got %0d, expected 5", d2_sc); end
        n_cmp++; if (d2_fe !== 16'd1) begin n_fail++; $display("FAIL perf_flush: got %0d, expected 1", d2_fe); end
        n_cmp++; if (d2_fc !== 32'd0) begin n_fail++; $display("FAIL perf_full: got %0d, expected 0", d2_fc); end
        step();
        d2_iv = 1'b1; d2_id = 32'h78;
        step();
        d2_iv = 1'b0;
        force u_d2.u_perf.stall_q = 32'hFFFF_FFFF;
        #1;
        release u_d2.u_perf.stall_q;
        step(); step(); step();
        @(negedge CLK);
        n_cmp++; if (d2_sc !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL perf_saturate: got %h, expected ffffffff", d2_sc); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        d2_flush = 1'b0; d2_iv = 1'b0; d2_or = 1'b0; d2_id = '0;
        d1_flush = 1'b0; d1_iv = 1'b0; d1_or = 1'b0; d1_id = '0;
        d3_flush = 1'b0; d3_iv = 1'b0; d3_or = 1'b0; d3_id = '0;
        test_reset();
        test_fill_drain();
        test_stream();
        test_flush();
        test_wrap();
`ifdef PIPE_STAGE_BUF_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_buf
